// File: rtl/rf_pkg.sv
// FunSel operation encodings shared by the register file and its cells.
package rf_pkg;

  localparam int unsigned FS_W = 3;

  localparam logic [FS_W-1:0] FS_DEC       = 3'b000;
  localparam logic [FS_W-1:0] FS_INC       = 3'b001;
  localparam logic [FS_W-1:0] FS_LOAD      = 3'b010;
  localparam logic [FS_W-1:0] FS_CLR       = 3'b011;
  localparam logic [FS_W-1:0] FS_LDL_CLRH  = 3'b100;
  localparam logic [FS_W-1:0] FS_LDL_KEEPH = 3'b101;
  localparam logic [FS_W-1:0] FS_SHL_LDL   = 3'b110;
  localparam logic [FS_W-1:0] FS_SEXT_L    = 3'b111;

endpackage : rf_pkg

// File: rtl/rf_cell.sv
// One register of the file: applies the selected FunSel op when enabled and
// exports its next-state value so the top can forward same-edge writes.
module rf_cell
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             E,
  input  logic [FS_W-1:0]  FunSel,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] D_next
);

  localparam int unsigned H = WIDTH / 2;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state: hold unless enabled, otherwise apply the requested op.
  always_comb begin
    q_d = q_q;
    if (E) begin
      case (FunSel)
        FS_DEC:       q_d = q_q - WIDTH'(1);
        FS_INC:       q_d = q_q + WIDTH'(1);
        FS_LOAD:      q_d = In;
        FS_CLR:       q_d = '0;
        FS_LDL_CLRH:  q_d = {{H{1'b0}}, In[H-1:0]};
        FS_LDL_KEEPH: q_d = {q_q[WIDTH-1:H], In[H-1:0]};
        FS_SHL_LDL:   q_d = {q_q[H-1:0], In[H-1:0]};
        FS_SEXT_L:    q_d = {{H{In[H-1]}}, In[H-1:0]};
        default:      q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign Q      = q_q;
  assign D_next = q_d;

endmodule : rf_cell

// File: rtl/param_register_file.sv
// Parametrised general + scratch register file with two registered read ports.
// Define RF_BYPASS_EN to forward same-edge writes to the read ports.
module param_register_file
  import rf_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned NREGS = 4,
  parameter  int unsigned NSCR  = 4,
  localparam int unsigned SELW  = $clog2(NREGS + NSCR)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREGS-1:0] RegSel,
  input  logic [NSCR-1:0]  ScrSel,
  input  logic [FS_W-1:0]  FunSel,
  input  logic [WIDTH-1:0] In,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int unsigned NTOT = NREGS + NSCR;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NTOT-1:0]  en;
  logic [WIDTH-1:0] q_arr  [NTOT];
  logic [WIDTH-1:0] d_arr  [NTOT];
  logic [WIDTH-1:0] rd_arr [NTOT];

  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;

  // Flat index 0 = R1; enable vectors are MSB-first (MSB = R1 / S1).
  for (genvar i = 0; i < NTOT; i++) begin : g_cell
    if (i < NREGS) begin : g_gen
      assign en[i] = RegSel[NREGS-1-i];
    end else begin : g_scr
      assign en[i] = ScrSel[NTOT-1-i];
    end

    rf_cell #(.WIDTH(WIDTH)) u_cell (
      .clock  (clock),
      .reset_n(reset_n),
      .E      (en[i]),
      .FunSel (FunSel),
      .In     (In),
      .Q      (q_arr[i]),
      .D_next (d_arr[i])
    );

    assign rd_arr[i] = BYPASS ? d_arr[i] : q_arr[i];
  end

  // Read muxes; selects beyond the last register read as zero.
  always_comb begin
    out_a_d = '0;
    out_b_d = '0;
    if (32'(OutASel) < NTOT) out_a_d = rd_arr[OutASel];
    if (32'(OutBSel) < NTOT) out_b_d = rd_arr[OutBSel];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign OutA = out_a_q;
  assign OutB = out_b_q;

endmodule : param_register_file

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file (WIDTH=32, NREGS=4, NSCR=4):
// directed scenarios plus random traffic against a behavioural model.
module tb_param_register_file;

  logic        clock;
  logic        reset_n;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  FunSel;
  logic [31:0] In;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  int unsigned pass_cnt  = 0;
  int unsigned fail_cnt  = 0;
  int unsigned check_cnt = 0;

  // Model: index 0..3 = R1..R4, 4..7 = S1..S4.
  logic [31:0] model [8];

`ifdef RF_BYPASS_EN
  localparam bit MODEL_BYPASS = 1'b1;
`else
  localparam bit MODEL_BYPASS = 1'b0;
`endif

  param_register_file #(.WIDTH(32), .NREGS(4), .NSCR(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .RegSel (RegSel),
    .ScrSel (ScrSel),
    .FunSel (FunSel),
    .In     (In),
    .OutASel(OutASel),
    .OutBSel(OutBSel),
    .OutA   (OutA),
    .OutB   (OutB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  function automatic logic [31:0] apply_op(input logic [2:0] fs, input logic [31:0] q,
                                           input logic [31:0] din);
    logic [31:0] lo;
    lo = din & 32'h0000_FFFF;
    case (fs)
      3'd0:    return q - 32'd1;
      3'd1:    return q + 32'd1;
      3'd2:    return din;
      3'd3:    return 32'd0;
      3'd4:    return lo;
      3'd5:    return (q & 32'hFFFF_0000) | lo;
      3'd6:    return (q << 16) | lo;
      default: return (din[15] ? 32'hFFFF_0000 : 32'h0) | lo;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, model the edge, check ports at next negedge.
  task automatic step(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs,
                      input logic [31:0] din, input logic [2:0] as, input logic [2:0] bs);
    logic [31:0] nxt [8];
    logic [31:0] exp_a, exp_b;
    RegSel = rs; ScrSel = ss; FunSel = fs; In = din; OutASel = as; OutBSel = bs;
    for (int i = 0; i < 8; i++) begin
      logic e;
      e = (i < 4) ? rs[3-i] : ss[7-i];
      nxt[i] = e ? apply_op(fs, model[i], din) : model[i];
    end
    exp_a = MODEL_BYPASS ? nxt[as] : model[as];
    exp_b = MODEL_BYPASS ? nxt[bs] : model[bs];
    @(posedge clock);
    for (int i = 0; i < 8; i++) model[i] = nxt[i];
    @(negedge clock);
    check("model_outa", OutA, exp_a);
    check("model_outb", OutB, exp_b);
  endtask

  initial begin
    reset_n = 1'b0;
    RegSel = '0; ScrSel = '0; FunSel = '0; In = '0; OutASel = '0; OutBSel = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (2) @(negedge clock);
    check("reset_outa", OutA, 32'h0);
    check("reset_outb", OutB, 32'h0);
    reset_n = 1'b1;

    // 2: load R1, read back next cycle
    step(4'b1000, 4'b0000, 3'b010, 32'hDEADBEEF, 3'd0, 3'd1);
    step(4'b0000, 4'b0000, 3'b010, 32'h0, 3'd0, 3'd0);
    check("load_r1", OutA, 32'hDEADBEEF);

    // 1: async reset mid-run after loads
    step(4'b0000, 4'b1111, 3'b010, 32'hCAFE0001, 3'd0, 3'd4);
    step(4'b0000, 4'b0000, 3'b000, 32'h0, 3'd5, 3'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_outa", OutA, 32'h0);
    check("async_rst_outb", OutB, 32'h0);
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 4'b0000, 3'b000, 32'h0, 3'(2*i), 3'(2*i+1));
      check("post_rst_a", OutA, 32'h0);
      check("post_rst_b", OutB, 32'h0);
    end

    // 3: R2 wrap both ways
    step(4'b0100, 4'b0000, 3'b010, 32'hFFFFFFFF, 3'd1, 3'd1);
    step(4'b0100, 4'b0000, 3'b001, 32'h0, 3'd1, 3'd1);
    step(4'b0000, 4'b0000, 3'b000, 32'h0, 3'd1, 3'd1);
    check("inc_wrap", OutA, 32'h0);
    step(4'b0100, 4'b0000, 3'b000, 32'h0, 3'd1, 3'd1);
    step(4'b0000, 4'b0000, 3'b000, 32'h0, 3'd1, 3'd1);
    check("dec_wrap", OutA, 32'hFFFFFFFF);

    // 4: half-word ops on S1
    step(4'b0000, 4'b1000, 3'b010, 32'h12345678, 3'd4, 3'd4);
    step(4'b0000, 4'b1000, 3'b101, 32'h0000ABCD, 3'd4, 3'd4);
    step(4'b0000, 4'b1000, 3'b110, 32'h00001111, 3'd4, 3'd4);
    check("ldl_keeph", OutA, MODEL_BYPASS ? 32'hABCD1111 : 32'h1234ABCD);
    step(4'b0000, 4'b1000, 3'b111, 32'h00008001, 3'd4, 3'd4);
    check("shl_ldl", OutA, MODEL_BYPASS ? 32'hFFFF8001 : 32'hABCD1111);
    step(4'b0000, 4'b1000, 3'b100, 32'hFFFF0007, 3'd4, 3'd4);
    check("sext_l", OutA, MODEL_BYPASS ? 32'h00000007 : 32'hFFFF8001);
    step(4'b0000, 4'b0000, 3'b000, 32'h0, 3'd4, 3'd4);
    check("ldl_clrh", OutB, 32'h00000007);

    // 5: clear all general regs, scratch untouched; read S4 on port B
    step(4'b1111, 4'b1111, 3'b010, 32'h0BADF00D, 3'd0, 3'd7);
    step(4'b1111, 4'b0000, 3'b011, 32'h0, 3'd0, 3'd7);
    step(4'b0000, 4'b0000, 3'b000, 32'h0, 3'd3, 3'd7);
    check("clr_r4", OutA, 32'h0);
    check("s4_kept", OutB, 32'h0BADF00D);

    // 6: same-edge write/read of R3
    step(4'b0010, 4'b0000, 3'b010, 32'h11, 3'd2, 3'd2);
    step(4'b0010, 4'b0000, 3'b010, 32'h55, 3'd2, 3'd6);
    check("same_edge", OutA, MODEL_BYPASS ? 32'h55 : 32'h11);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom), 4'($urandom), 3'($urandom), $urandom, 3'($urandom), 3'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_param_register_file
